// File: rtl/rs_pkg.sv
// Shared types and helpers for the reservation station.
// Latency: none (declarations only).
// Backpressure: n/a.
//
// Defaults describe the baseline core configuration. The station itself is
// parametrised, so it derives its own widths from its parameters and uses
// cnt_width() to size the occupancy counter.
package rs_pkg;

  localparam int RS_DEPTH  = 8;
  localparam int RS_PREG_W = 6;
  localparam int RS_AREG_W = 5;
  localparam int RS_ROB_W  = 5;
  localparam int RS_OP_W   = 32;

  localparam int CNT_W = $clog2(RS_DEPTH) + 1;

  // One station slot in the baseline configuration.
  typedef struct packed {
    logic                 valid;
    logic                 rdy1;
    logic                 rdy2;
    logic [RS_PREG_W-1:0] ps1;
    logic [RS_PREG_W-1:0] ps2;
    logic [RS_PREG_W-1:0] pd;
    logic [RS_AREG_W-1:0] rd;
    logic [RS_ROB_W-1:0]  rob;
    logic [RS_OP_W-1:0]   op;
  } rs_entry_t;

  // Occupancy counter width: must be able to hold DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// Oldest-candidate picker: grants the candidate that no other candidate is older than.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
//
// Ports:
//   cand        - candidate vector, one bit per entry
//   age         - flattened age matrix, age[i*DEPTH+j] = 1 when entry i is older than j
//   grant       - one-hot winner (all zero when there are no candidates)
//   grant_valid - at least one candidate exists
module rs_oldest_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]       cand,
  input  logic [DEPTH*DEPTH-1:0] age,
  output logic [DEPTH-1:0]       grant,
  output logic                   grant_valid
);

  logic [DEPTH-1:0] blocked;

  // Entry i loses if any other candidate j is older than it (column i of the matrix).
  always_comb begin
    blocked = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && cand[j] && age[j*DEPTH+i]) blocked[i] = 1'b1;
      end
    end
  end

  assign grant       = cand & ~blocked;
  assign grant_valid = |cand;

endmodule

// File: rtl/reservation_station_param.sv
// Unified reservation station: holds dispatched ops, wakes sources from the CDB, issues oldest ready op.
// Latency: ready dispatch -> iss_valid next cycle; CDB wakeup -> eligible next cycle.
// Backpressure: disp_ready low when full (request dropped, sender holds); entry leaves only on iss_valid && iss_ready.
//
// Ports: disp_* dispatch request/fields, cdb_valid/cdb_pd wakeup broadcasts (port k at [k*PREG_W +: PREG_W]),
// iss_* issue handshake and fields of the winning entry, flush synchronous squash, count occupancy.
module reservation_station_param
  import rs_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 6,
  parameter int AREG_W = 5,
  parameter int ROB_W  = 5,
  parameter int N_CDB  = 2,
  parameter int OP_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    disp_valid,
  output logic                    disp_ready,
  input  logic [PREG_W-1:0]       disp_ps1,
  input  logic [PREG_W-1:0]       disp_ps2,
  input  logic                    disp_ps1_rdy,
  input  logic                    disp_ps2_rdy,
  input  logic [PREG_W-1:0]       disp_pd,
  input  logic [AREG_W-1:0]       disp_rd,
  input  logic [ROB_W-1:0]        disp_rob,
  input  logic [OP_W-1:0]         disp_op,
  input  logic [N_CDB-1:0]        cdb_valid,
  input  logic [N_CDB*PREG_W-1:0] cdb_pd,
  output logic                    iss_valid,
  input  logic                    iss_ready,
  output logic [PREG_W-1:0]       iss_ps1,
  output logic [PREG_W-1:0]       iss_ps2,
  output logic [PREG_W-1:0]       iss_pd,
  output logic [AREG_W-1:0]       iss_rd,
  output logic [ROB_W-1:0]        iss_rob,
  output logic [OP_W-1:0]         iss_op,
  input  logic                    flush,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int CW    = cnt_width(DEPTH);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic              rdy1;
    logic              rdy2;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic [PREG_W-1:0] pd;
    logic [AREG_W-1:0] rd;
    logic [ROB_W-1:0]  rob;
    logic [OP_W-1:0]   op;
  } entry_t;

  entry_t           ent     [DEPTH];
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [CW-1:0]    count_q;

  logic [DEPTH-1:0]       valid_vec;
  logic [DEPTH-1:0]       cand;
  logic [DEPTH*DEPTH-1:0] age_flat;
  logic [DEPTH-1:0]       grant;
  logic                   grant_valid;
  logic [IDX_W-1:0]       free_idx;
  logic                   alloc;
  logic                   fire;

  // Tag 0 is the hardwired-ready register and never counts as a broadcast hit.
  function automatic logic cdb_hit(input logic [PREG_W-1:0] tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < N_CDB; k++) begin
      if (cdb_valid[k] && cdb_pd[k*PREG_W +: PREG_W] == tag && tag != '0) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    valid_vec = '0;
    cand      = '0;
    age_flat  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent[i].valid;
      cand[i]      = ent[i].valid && ent[i].rdy1 && ent[i].rdy2;
      for (int j = 0; j < DEPTH; j++) age_flat[i*DEPTH+j] = older_q[i][j];
    end
  end

  // Lowest free slot; scanning downward lets the lowest index win.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent[i].valid) free_idx = IDX_W'(i);
    end
  end

  rs_oldest_select #(.DEPTH(DEPTH)) u_select (
    .cand        (cand),
    .age         (age_flat),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign disp_ready = (count_q != CW'(DEPTH));
  assign alloc      = disp_valid && disp_ready;
  assign fire       = grant_valid && iss_ready;
  assign count      = count_q;
  assign iss_valid  = grant_valid;

  // Grant is one-hot, so a plain overwrite is a clean mux; all-zero when idle.
  always_comb begin
    iss_ps1 = '0;
    iss_ps2 = '0;
    iss_pd  = '0;
    iss_rd  = '0;
    iss_rob = '0;
    iss_op  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        iss_ps1 = ent[i].ps1;
        iss_ps2 = ent[i].ps2;
        iss_pd  = ent[i].pd;
        iss_rd  = ent[i].rd;
        iss_rob = ent[i].rob;
        iss_op  = ent[i].op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i]     <= '0;
        older_q[i] <= '0;
      end
      count_q <= '0;
    end else if (flush) begin
      // Stale age bits are harmless: a slot's row is rewritten when it is reallocated.
      for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent[i].valid && cdb_hit(ent[i].ps1)) ent[i].rdy1 <= 1'b1;
        if (ent[i].valid && cdb_hit(ent[i].ps2)) ent[i].rdy2 <= 1'b1;
        if (fire && grant[i]) ent[i].valid <= 1'b0;
      end
      if (alloc) begin
        // free_idx comes from registered state, so it never collides with the issuing slot.
        ent[free_idx].valid <= 1'b1;
        ent[free_idx].rdy1  <= disp_ps1_rdy || (disp_ps1 == '0) || cdb_hit(disp_ps1);
        ent[free_idx].rdy2  <= disp_ps2_rdy || (disp_ps2 == '0) || cdb_hit(disp_ps2);
        ent[free_idx].ps1   <= disp_ps1;
        ent[free_idx].ps2   <= disp_ps2;
        ent[free_idx].pd    <= disp_pd;
        ent[free_idx].rd    <= disp_rd;
        ent[free_idx].rob   <= disp_rob;
        ent[free_idx].op    <= disp_op;
        // Everything already resident is older than the newcomer.
        for (int j = 0; j < DEPTH; j++) older_q[j][free_idx] <= ent[j].valid;
        older_q[free_idx] <= '0;
      end
      count_q <= count_q + CW'(alloc) - CW'(fire);
    end
  end

  logic antisym_ok;
  always_comb begin
    antisym_ok = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (i != j && ent[i].valid && ent[j].valid && older_q[i][j] == older_q[j][i])
          antisym_ok = 1'b0;
      end
    end
  end

  a_count_popcount: assert property (@(posedge clk) disable iff (!rst_n)
    count_q == CW'($countones(valid_vec)));
  a_age_antisym: assert property (@(posedge clk) disable iff (!rst_n) antisym_ok);

endmodule

// File: tb/tb_reservation_station_param.sv
module tb_reservation_station_param;

  localparam int DEPTH  = 8;
  localparam int PREG_W = 6;
  localparam int AREG_W = 5;
  localparam int ROB_W  = 5;
  localparam int N_CDB  = 2;
  localparam int OP_W   = 32;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    disp_valid, disp_ready;
  logic [PREG_W-1:0]       disp_ps1, disp_ps2, disp_pd;
  logic                    disp_ps1_rdy, disp_ps2_rdy;
  logic [AREG_W-1:0]       disp_rd;
  logic [ROB_W-1:0]        disp_rob;
  logic [OP_W-1:0]         disp_op;
  logic [N_CDB-1:0]        cdb_valid;
  logic [N_CDB*PREG_W-1:0] cdb_pd;
  logic                    iss_valid, iss_ready;
  logic [PREG_W-1:0]       iss_ps1, iss_ps2, iss_pd;
  logic [AREG_W-1:0]       iss_rd;
  logic [ROB_W-1:0]        iss_rob;
  logic [OP_W-1:0]         iss_op;
  logic                    flush;
  logic [CW-1:0]           count;

  int n_cmp  = 0;
  int n_fail = 0;

  reservation_station_param #(
    .DEPTH(DEPTH), .PREG_W(PREG_W), .AREG_W(AREG_W),
    .ROB_W(ROB_W), .N_CDB(N_CDB), .OP_W(OP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_ps1(disp_ps1), .disp_ps2(disp_ps2),
    .disp_ps1_rdy(disp_ps1_rdy), .disp_ps2_rdy(disp_ps2_rdy),
    .disp_pd(disp_pd), .disp_rd(disp_rd), .disp_rob(disp_rob), .disp_op(disp_op),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_ps1(iss_ps1), .iss_ps2(iss_ps2), .iss_pd(iss_pd),
    .iss_rd(iss_rd), .iss_rob(iss_rob), .iss_op(iss_op),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_disp(input logic v, input logic [PREG_W-1:0] p1, input logic r1,
                            input logic [PREG_W-1:0] p2, input logic r2,
                            input logic [PREG_W-1:0] pd, input logic [ROB_W-1:0] rob);
    disp_valid = v; disp_ps1 = p1; disp_ps1_rdy = r1; disp_ps2 = p2; disp_ps2_rdy = r2;
    disp_pd = pd; disp_rob = rob; disp_rd = pd[AREG_W-1:0]; disp_op = {26'd0, pd};
  endtask

  task automatic idle_inputs();
    drive_disp(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    cdb_valid = '0; cdb_pd = '0; iss_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #2;
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready got %b want 1", disp_ready); end
    n_cmp++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iss_valid got %b want 0", iss_valid); end
    n_cmp++; if ({iss_ps1, iss_ps2, iss_pd, iss_rd, iss_rob, iss_op} !== '0) begin
      n_fail++; $display("FAIL reset_iss_fields got pd=%0d op=%h want all 0", iss_pd, iss_op); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic_issue();
    drive_disp(1'b1, 6'd32, 1'b1, 6'd33, 1'b1, 6'd45, 5'd0);
    n_cmp++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pre_iss got %b want 0", iss_valid); end
    cyc();
    disp_valid = 1'b0;
    n_cmp++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL basic_iss_valid got %b want 1", iss_valid); end
    n_cmp++; if (iss_pd !== 6'd45) begin n_fail++; $display("FAIL basic_iss_pd got %0d want 45", iss_pd); end
    n_cmp++; if (iss_ps1 !== 6'd32 || iss_ps2 !== 6'd33) begin
      n_fail++; $display("FAIL basic_iss_srcs got %0d/%0d want 32/33", iss_ps1, iss_ps2); end
    n_cmp++; if (count !== CW'(1)) begin n_fail++; $display("FAIL basic_count1 got %0d want 1", count); end
    iss_ready = 1'b1;
    cyc();
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL basic_count0 got %0d want 0", count); end
    n_cmp++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty got %b want 0", iss_valid); end
    idle_inputs();
  endtask

  task automatic test_wakeup();
    iss_ready = 1'b1;
    drive_disp(1'b1, 6'd32, 1'b1, 6'd33, 1'b0, 6'd45, 5'd1);
    cyc();
    disp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL wake_wait%0d got %b want 0", c, iss_valid); end
      cyc();
    end
    cdb_valid = 2'b10;
    cdb_pd    = {6'd33, 6'd0};
    #1;
    n_cmp++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL wake_no_comb_path got %b want 0", iss_valid); end
    cyc();
    cdb_valid = '0;
    n_cmp++; if (iss_valid !== 1'b1 || iss_pd !== 6'd45) begin
      n_fail++; $display("FAIL wake_issue got v=%b pd=%0d want v=1 pd=45", iss_valid, iss_pd); end
    cyc();
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL wake_drain got %0d want 0", count); end
    idle_inputs();
  endtask

  task automatic test_bypass();
    iss_ready = 1'b1;
    drive_disp(1'b1, 6'd5, 1'b1, 6'd38, 1'b0, 6'd46, 5'd2);
    cdb_valid = 2'b01;
    cdb_pd    = {6'd0, 6'd38};
    cyc();
    disp_valid = 1'b0; cdb_valid = '0;
    n_cmp++; if (iss_valid !== 1'b1 || iss_pd !== 6'd46) begin
      n_fail++; $display("FAIL bypass_issue got v=%b pd=%0d want v=1 pd=46", iss_valid, iss_pd); end
    cyc();
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL bypass_drain got %0d want 0", count); end
    idle_inputs();
  endtask

  task automatic test_age_full();
    for (int i = 0; i < DEPTH; i++) begin
      drive_disp(1'b1, 6'd50, 1'b0, 6'd1, 1'b1, 6'(10 + i), 5'(i));
      cyc();
    end
    disp_valid = 1'b0;
    n_cmp++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_count got %0d want %0d", count, DEPTH); end
    n_cmp++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_disp_ready got %b want 0", disp_ready); end
    n_cmp++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL full_iss_valid got %b want 0", iss_valid); end
    // Request while full must be dropped.
    drive_disp(1'b1, 6'd0, 1'b1, 6'd0, 1'b1, 6'd63, 5'd31);
    cyc();
    disp_valid = 1'b0;
    n_cmp++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_drop got %0d want %0d", count, DEPTH); end
    cdb_valid = 2'b01; cdb_pd = {6'd0, 6'd50}; iss_ready = 1'b1;
    cyc();
    cdb_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++; if (iss_valid !== 1'b1 || iss_pd !== 6'(10 + i) || count !== CW'(DEPTH - i)) begin
        n_fail++; $display("FAIL age_order%0d got v=%b pd=%0d cnt=%0d want v=1 pd=%0d cnt=%0d",
                           i, iss_valid, iss_pd, count, 10 + i, DEPTH - i); end
      cyc();
    end
    n_cmp++; if (count !== '0 || iss_valid !== 1'b0) begin
      n_fail++; $display("FAIL age_drain got cnt=%0d v=%b want 0/0", count, iss_valid); end
    idle_inputs();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive_disp(1'b1, 6'd2, 1'b1, 6'd3, 1'b1, 6'(20 + i), 5'(i));
      cyc();
    end
    disp_valid = 1'b0;
    n_cmp++; if (count !== CW'(3) || iss_pd !== 6'd20) begin
      n_fail++; $display("FAIL flush_pre got cnt=%0d pd=%0d want 3/20", count, iss_pd); end
    drive_disp(1'b1, 6'd2, 1'b1, 6'd3, 1'b1, 6'd30, 5'd9);
    flush = 1'b1; iss_ready = 1'b1;
    cyc();
    idle_inputs();
    n_cmp++; if (count !== '0 || iss_valid !== 1'b0 || disp_ready !== 1'b1 || iss_pd !== '0) begin
      n_fail++; $display("FAIL flush_post got cnt=%0d v=%b dr=%b pd=%0d want 0/0/1/0",
                         count, iss_valid, disp_ready, iss_pd); end
    cyc();
    n_cmp++; if (count !== '0 || iss_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_settled got cnt=%0d v=%b want 0/0", count, iss_valid); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      drive_disp(1'b1, 6'd7, 1'b1, 6'd8, 1'b1, 6'(40 + i), 5'(i));
      cyc();
    end
    disp_valid = 1'b0;
    n_cmp++; if (count !== CW'(4) || iss_valid !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre got cnt=%0d v=%b want 4/1", count, iss_valid); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (count !== '0 || iss_valid !== 1'b0 || disp_ready !== 1'b1) begin
      n_fail++; $display("FAIL areset_immediate got cnt=%0d v=%b dr=%b want 0/0/1", count, iss_valid, disp_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    n_cmp++; if (count !== '0 || iss_valid !== 1'b0) begin
      n_fail++; $display("FAIL areset_after got cnt=%0d v=%b want 0/0", count, iss_valid); end
  endtask

  // Reference: station contents kept as a list in dispatch order; issue takes the
  // first fully ready element of the list.
  typedef struct {
    logic [PREG_W-1:0] ps1, ps2, pd;
    logic [AREG_W-1:0] rd;
    logic [ROB_W-1:0]  rob;
    logic [OP_W-1:0]   op;
    bit                r1, r2;
  } m_t;

  function automatic bit tag_hit(input logic [PREG_W-1:0] t, input logic [N_CDB-1:0] cv,
                                 input logic [N_CDB*PREG_W-1:0] cp);
    for (int k = 0; k < N_CDB; k++)
      if (t != 0 && cv[k] && cp[k*PREG_W +: PREG_W] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_random();
    m_t mq[$];
    m_t ne;
    int win;
    flush = 1'b1;
    cyc();
    idle_inputs();
    for (int c = 0; c < 600; c++) begin
      win = -1;
      for (int i = 0; i < mq.size(); i++)
        if (win < 0 && mq[i].r1 && mq[i].r2) win = i;
      n_cmp++; if (count !== CW'(mq.size()) || disp_ready !== (mq.size() != DEPTH)) begin
        n_fail++; $display("FAIL rand_occ c=%0d got cnt=%0d dr=%b want cnt=%0d", c, count, disp_ready, mq.size()); end
      n_cmp++;
      if (win < 0) begin
        if (iss_valid !== 1'b0 || iss_pd !== '0 || iss_op !== '0) begin
          n_fail++; $display("FAIL rand_idle c=%0d got v=%b pd=%0d want v=0 pd=0", c, iss_valid, iss_pd); end
      end else if (iss_valid !== 1'b1 || iss_pd !== mq[win].pd || iss_ps1 !== mq[win].ps1 ||
                   iss_ps2 !== mq[win].ps2 || iss_rd !== mq[win].rd || iss_rob !== mq[win].rob ||
                   iss_op !== mq[win].op) begin
        n_fail++; $display("FAIL rand_issue c=%0d got v=%b pd=%0d rob=%0d want v=1 pd=%0d rob=%0d",
                           c, iss_valid, iss_pd, iss_rob, mq[win].pd, mq[win].rob);
      end
      // New stimulus for the coming edge.
      disp_valid   = ($urandom_range(0, 9) < 6);
      disp_ps1     = 6'($urandom_range(0, 7));
      disp_ps2     = 6'($urandom_range(0, 7));
      disp_ps1_rdy = ($urandom_range(0, 9) < 3);
      disp_ps2_rdy = ($urandom_range(0, 9) < 3);
      disp_pd      = 6'($urandom);
      disp_rd      = 5'($urandom);
      disp_rob     = 5'($urandom);
      disp_op      = $urandom;
      cdb_valid    = 2'($urandom);
      cdb_pd       = {6'($urandom_range(1, 7)), 6'($urandom_range(1, 7))};
      iss_ready    = ($urandom_range(0, 9) < 6);
      flush        = ($urandom_range(0, 99) < 3);
      // Advance the reference across the edge.
      if (flush) begin
        mq.delete();
      end else begin
        bit can_alloc;
        can_alloc = disp_valid && (mq.size() < DEPTH);
        for (int i = 0; i < mq.size(); i++) begin
          if (tag_hit(mq[i].ps1, cdb_valid, cdb_pd)) mq[i].r1 = 1'b1;
          if (tag_hit(mq[i].ps2, cdb_valid, cdb_pd)) mq[i].r2 = 1'b1;
        end
        if (win >= 0 && iss_ready) mq.delete(win);
        if (can_alloc) begin
          ne.ps1 = disp_ps1; ne.ps2 = disp_ps2; ne.pd = disp_pd;
          ne.rd = disp_rd; ne.rob = disp_rob; ne.op = disp_op;
          ne.r1 = disp_ps1_rdy || disp_ps1 == 0 || tag_hit(disp_ps1, cdb_valid, cdb_pd);
          ne.r2 = disp_ps2_rdy || disp_ps2 == 0 || tag_hit(disp_ps2, cdb_valid, cdb_pd);
          mq.push_back(ne);
        end
      end
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_bypass();
    test_age_full();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
